// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its interval timer:
// timer state encodings and the default interval parameters both sides agree on.
package traffic_pkg;

  typedef enum logic [1:0] {
    RUN_S = 2'b00,
    RUN_L = 2'b01,
    EXP   = 2'b10
  } timer_state_e;

  localparam int DEF_PRESCALE = 4;
  localparam int DEF_SHORT_T  = 3;
  localparam int DEF_LONG_T   = 8;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/traffic_timer_if.sv
// Timer handshake between the traffic-light controller (master) and the
// interval timer (slave).
interface traffic_timer_if #(
  parameter int CW = 4
);

  logic          st;
  logic          ts;
  logic          tl;
  logic          tick;
  logic [CW-1:0] elapsed;

  modport master (
    output st,
    input  ts,
    input  tl,
    input  tick,
    input  elapsed
  );

  modport slave (
    input  st,
    output ts,
    output tl,
    output tick,
    output elapsed
  );

endinterface

// File: rtl/tl_prescaler.sv
// Mod-PRESCALE counter that turns clk into time units; frozen at zero while
// the timer sits in its expired state.
module tl_prescaler
  import traffic_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int            PW    = cnt_width(PRESCALE);
  localparam logic [PW-1:0] P_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] p;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clr || hold) begin
      p <= '0;
    end else if (p == P_MAX) begin
      p <= '0;
    end else begin
      p <= p + PW'(1);
    end
  end

  // Suppressed while held so no increment is ever requested from EXP.
  assign tick = (p == P_MAX) && !hold;

endmodule

// File: rtl/traffic_timer.sv
// Interval timer for the traffic-light controller: after each start strobe it
// raises ts after SHORT_T time units and tl after LONG_T time units.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int SHORT_T  = DEF_SHORT_T,
  parameter int LONG_T   = DEF_LONG_T,
  parameter int CW       = 4
) (
  input logic            clk,
  input logic            rst,
  traffic_timer_if.slave tif
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("traffic_timer: PRESCALE must be at least 1");
  end
  if (SHORT_T < 1) begin : g_bad_short
    $error("traffic_timer: SHORT_T must be at least 1");
  end
  if (SHORT_T >= LONG_T) begin : g_bad_order
    $error("traffic_timer: SHORT_T must be less than LONG_T");
  end
  if (CW < $clog2(LONG_T + 1)) begin : g_bad_width
    $error("traffic_timer: CW too narrow to hold LONG_T");
  end

  localparam logic [CW-1:0] SHORT_C = CW'(SHORT_T);
  localparam logic [CW-1:0] LONG_C  = CW'(LONG_T);

  timer_state_e  state_q, state_d;
  logic [CW-1:0] elapsed_q, elapsed_d, elapsed_inc;
  logic          ts_q, tl_q;
  logic          tick;

  tl_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (tif.st),
    .hold (state_q == EXP),
    .tick (tick)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the branches can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    elapsed_d   = elapsed_q;
    elapsed_inc = elapsed_q + CW'(1);

    // A start strobe wins over a coincident tick; that increment is dropped.
    if (tif.st) begin
      state_d   = RUN_S;
      elapsed_d = '0;
    end else begin
      case (state_q)
        RUN_S: begin
          if (tick) begin
            elapsed_d = elapsed_inc;
            if (elapsed_inc == SHORT_C) state_d = RUN_L;
          end
        end
        RUN_L: begin
          if (tick) begin
            elapsed_d = elapsed_inc;
            if (elapsed_inc == LONG_C) state_d = EXP;
          end
        end
        EXP: begin
          elapsed_d = LONG_C;
        end
        default: begin
          state_d   = RUN_S;
          elapsed_d = '0;
        end
      endcase
    end
  end

  // Flags are flopped from the next state so they change on the same edge as
  // the state itself and never see st combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN_S;
      elapsed_q <= '0;
      ts_q      <= 1'b0;
      tl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      ts_q      <= (state_d == RUN_L) || (state_d == EXP);
      tl_q      <= (state_d == EXP);
    end
  end

  assign tif.ts      = ts_q;
  assign tif.tl      = tl_q;
  assign tif.tick    = tick;
  assign tif.elapsed = elapsed_q;

endmodule

// File: tb/tb_traffic_timer.sv
// Bench for traffic_timer: a default-parameter instance and a PRESCALE=1,
// SHORT_T=1, LONG_T=2 instance, both checked against an edge-count model.
module tb_traffic_timer;
  import traffic_pkg::*;

  localparam int PA = DEF_PRESCALE;
  localparam int SA = DEF_SHORT_T;
  localparam int LA = DEF_LONG_T;
  localparam int PB = 1;
  localparam int SB = 1;
  localparam int LB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_timer_if #(.CW(4)) tif_a ();
  traffic_timer_if #(.CW(2)) tif_b ();

  traffic_timer #(.PRESCALE(PA), .SHORT_T(SA), .LONG_T(LA), .CW(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .tif (tif_a.slave)
  );

  traffic_timer #(.PRESCALE(PB), .SHORT_T(SB), .LONG_T(LB), .CW(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .tif (tif_b.slave)
  );

  int total = 0;
  int bad   = 0;
  // Edges since the last edge at which rst or st was sampled high (saturating).
  int s_a   = 0;
  int s_b   = 0;

  // Expected {ts, tl, tick, elapsed[3:0]} after s edges of uninterrupted counting.
  function automatic logic [6:0] model(input int p, input int sht, input int lng, input int s);
    int   el;
    logic ts_e, tl_e, tk_e;
    el = s / p;
    if (el > lng) el = lng;
    ts_e = (s >= sht * p);
    tl_e = (s >= lng * p);
    tk_e = ((s % p) == (p - 1)) && (s < lng * p);
    return {ts_e, tl_e, tk_e, el[3:0]};
  endfunction

  function automatic logic [6:0] obs_a();
    return {tif_a.ts, tif_a.tl, tif_a.tick, tif_a.elapsed};
  endfunction

  function automatic logic [6:0] obs_b();
    return {tif_b.ts, tif_b.tl, tif_b.tick, 2'b00, tif_b.elapsed};
  endfunction

  // Advance one clock edge and update the reference edge counts.
  task automatic step();
    logic ca, cb;
    ca = rst | tif_a.st;
    cb = rst | tif_b.st;
    @(posedge clk);
    #1;
    s_a = ca ? 0 : ((s_a < LA * PA) ? s_a + 1 : s_a);
    s_b = cb ? 0 : ((s_b < LB * PB) ? s_b + 1 : s_b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tif_a.st = 1'b0;
    tif_b.st = 1'b0;
    step();
    step();
    total++;
    if (obs_a() !== 7'b000_0000) begin
      bad++;
      $display("FAIL reset_a got=%h want=%h", obs_a(), 7'b000_0000);
    end
    total++;
    if (obs_b() !== 7'b001_0000) begin
      bad++;
      $display("FAIL reset_b got=%h want=%h", obs_b(), 7'b001_0000);
    end
    rst = 1'b0;
  endtask

  task automatic test_defaults();
    int ts_a = -1, tl_a = -1, ts_b = -1, tl_b = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (ts_a < 0 && tif_a.ts === 1'b1) ts_a = k;
      if (tl_a < 0 && tif_a.tl === 1'b1) tl_a = k;
      if (ts_b < 0 && tif_b.ts === 1'b1) ts_b = k;
      if (tl_b < 0 && tif_b.tl === 1'b1) tl_b = k;
      total++;
      if (obs_a() !== model(PA, SA, LA, s_a)) begin
        bad++;
        $display("FAIL defaults_a edge=%0d got=%h want=%h", k, obs_a(), model(PA, SA, LA, s_a));
      end
      total++;
      if (obs_b() !== model(PB, SB, LB, s_b)) begin
        bad++;
        $display("FAIL defaults_b edge=%0d got=%h want=%h", k, obs_b(), model(PB, SB, LB, s_b));
      end
    end
    total++;
    if (ts_a !== 12 || tl_a !== 32) begin
      bad++;
      $display("FAIL defaults_rise_a got ts=%0d tl=%0d want ts=12 tl=32", ts_a, tl_a);
    end
    total++;
    if (ts_b !== 1 || tl_b !== 2) begin
      bad++;
      $display("FAIL defaults_rise_b got ts=%0d tl=%0d want ts=1 tl=2", ts_b, tl_b);
    end
    total++;
    if (tif_a.elapsed !== 4'd8 || tif_a.tick !== 1'b0) begin
      bad++;
      $display("FAIL defaults_exp got el=%0d tick=%b want el=8 tick=0", tif_a.elapsed, tif_a.tick);
    end
  endtask

  task automatic test_restart();
    int n, nb;
    tif_a.st = 1'b1;
    tif_b.st = 1'b1;
    step();
    tif_a.st = 1'b0;
    tif_b.st = 1'b0;
    for (int k = 0; k < 60 && tif_a.elapsed !== 4'd5; k++) begin
      step();
      total++;
      if (obs_a() !== model(PA, SA, LA, s_a)) begin
        bad++;
        $display("FAIL restart_run got=%h want=%h", obs_a(), model(PA, SA, LA, s_a));
      end
    end
    total++;
    if (tif_a.elapsed !== 4'd5 || tif_a.ts !== 1'b1) begin
      bad++;
      $display("FAIL restart_reach got el=%0d ts=%b want el=5 ts=1", tif_a.elapsed, tif_a.ts);
    end
    tif_a.st = 1'b1;
    tif_b.st = 1'b1;
    step();
    tif_a.st = 1'b0;
    tif_b.st = 1'b0;
    total++;
    if (tif_a.elapsed !== 4'd0 || tif_a.ts !== 1'b0 || tif_a.tl !== 1'b0) begin
      bad++;
      $display("FAIL restart_clear got el=%0d ts=%b tl=%b want 0 0 0", tif_a.elapsed, tif_a.ts, tif_a.tl);
    end
    n  = 0;
    nb = -1;
    while (tif_a.ts !== 1'b1 && n < 60) begin
      step();
      n++;
      if (nb < 0 && tif_b.ts === 1'b1) nb = n;
      total++;
      if (obs_a() !== model(PA, SA, LA, s_a)) begin
        bad++;
        $display("FAIL restart_rerun got=%h want=%h", obs_a(), model(PA, SA, LA, s_a));
      end
    end
    total++;
    if (n !== 12 || nb !== 1) begin
      bad++;
      $display("FAIL restart_rise got a=%0d b=%0d want a=12 b=1", n, nb);
    end
  endtask

  task automatic test_coincidence();
    for (int k = 0; k < 20 && tif_a.tick !== 1'b1; k++) step();
    total++;
    if (tif_a.tick !== 1'b1 || tif_a.elapsed === 4'd0) begin
      bad++;
      $display("FAIL coinc_wait got tick=%b el=%0d want tick=1 el>0", tif_a.tick, tif_a.elapsed);
    end
    tif_a.st = 1'b1;
    tif_b.st = 1'b1;
    step();
    tif_a.st = 1'b0;
    tif_b.st = 1'b0;
    total++;
    if (tif_a.elapsed !== 4'd0 || tif_b.elapsed !== 2'd0) begin
      bad++;
      $display("FAIL coinc_lost got a=%0d b=%0d want 0 0", tif_a.elapsed, tif_b.elapsed);
    end
  endtask

  task automatic test_hold();
    int n;
    tif_a.st = 1'b1;
    tif_b.st = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (obs_a() !== model(PA, SA, LA, s_a) || tif_a.elapsed !== 4'd0) begin
        bad++;
        $display("FAIL hold_a cyc=%0d got=%h want=%h", k, obs_a(), model(PA, SA, LA, s_a));
      end
      total++;
      if (obs_b() !== model(PB, SB, LB, s_b)) begin
        bad++;
        $display("FAIL hold_b cyc=%0d got=%h want=%h", k, obs_b(), model(PB, SB, LB, s_b));
      end
    end
    tif_a.st = 1'b0;
    tif_b.st = 1'b0;
    n = 0;
    while (tif_a.ts !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    total++;
    if (n !== 12) begin
      bad++;
      $display("FAIL hold_rise got=%0d want=12", n);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      tif_a.st = ($urandom_range(0, 15) == 0);
      tif_b.st = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      step();
      total++;
      if (obs_a() !== model(PA, SA, LA, s_a)) begin
        bad++;
        $display("FAIL random_a cyc=%0d got=%h want=%h", k, obs_a(), model(PA, SA, LA, s_a));
      end
      total++;
      if (obs_b() !== model(PB, SB, LB, s_b)) begin
        bad++;
        $display("FAIL random_b cyc=%0d got=%h want=%h", k, obs_b(), model(PB, SB, LB, s_b));
      end
    end
    rst      = 1'b0;
    tif_a.st = 1'b0;
    tif_b.st = 1'b0;
  endtask

  task automatic test_reset_mid();
    tif_a.st = 1'b1;
    tif_b.st = 1'b1;
    step();
    tif_a.st = 1'b0;
    tif_b.st = 1'b0;
    for (int k = 0; k < 18; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (obs_a() !== 7'b000_0000) begin
      bad++;
      $display("FAIL reset_mid_a got=%h want=%h", obs_a(), 7'b000_0000);
    end
    total++;
    if (obs_b() !== 7'b001_0000) begin
      bad++;
      $display("FAIL reset_mid_b got=%h want=%h", obs_b(), 7'b001_0000);
    end
  endtask

  initial begin
    tif_a.st = 1'b0;
    tif_b.st = 1'b0;
    test_reset();
    test_defaults();
    test_restart();
    test_coincidence();
    test_hold();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
